// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory path: access-size bit positions,
// store-buffer FSM encodings and the memory-mapped LED address.
package mem_pkg;

    localparam int unsigned SM_SIGNED = 32'd3;
    localparam int unsigned SM_WORD   = 32'd2;
    localparam int unsigned SM_HALF   = 32'd1;
    localparam int unsigned SM_BYTE   = 32'd0;

    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

    typedef enum logic [2:0] {
        SB_IDLE            = 3'd0,
        SB_DRAIN           = 3'd1,
        SB_LOAD_WAIT_DRAIN = 3'd2,
        SB_LOAD            = 3'd3,
        SB_LOAD_DONE       = 3'd4
    } sb_state_e;

    function automatic logic is_word(input logic [3:0] sign_mask);
        return sign_mask[SM_WORD];
    endfunction

endpackage

// File: rtl/sb_checker.sv
// Simulation-only protocol checks for the store buffer.
module sb_checker (
    input logic clk,
    input logic reset,
    input logic cpu_read,
    input logic cpu_write,
    input logic mem_read,
    input logic mem_write
);

    a_no_cpu_rw_conflict: assert property (@(posedge clk) disable iff (reset)
        !(cpu_read && cpu_write));

    a_no_mem_rw_overlap: assert property (@(posedge clk) disable iff (reset)
        !(mem_read && mem_write));

endmodule

// File: rtl/sb_fifo.sv
// Pending-store FIFO: holds {addr, wdata, sign_mask}, exposes the head entry
// and a per-slot word-address match vector used for load forwarding.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [31:0]             push_addr,
    input  logic [31:0]             push_wdata,
    input  logic [3:0]              push_mask,
    input  logic [29:0]             cmp_word,
    output logic [31:0]             head_addr,
    output logic [31:0]             head_wdata,
    output logic [3:0]              head_mask,
    output logic [PTR_W-1:0]        head_ptr,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH-1:0]        match,
    output logic [DEPTH-1:0][31:0]  entry_wdata
);

    logic [31:0]      addr_r  [DEPTH];
    logic [31:0]      wdata_r [DEPTH];
    logic [3:0]       mask_r  [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;

    assign head_addr  = addr_r[head_r];
    assign head_wdata = wdata_r[head_r];
    assign head_mask  = mask_r[head_r];
    assign head_ptr   = head_r;
    assign full       = (count_r == (PTR_W+1)'(DEPTH));
    assign empty      = (count_r == (PTR_W+1)'(0));

    // A slot only matches while it is occupied, i.e. its offset from head is below count
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PTR_W-1:0] off_s;
        assign off_s          = PTR_W'(g) - head_r;
        assign match[g]       = ({1'b0, off_s} < count_r)
                              && (addr_r[g][31:2] == cmp_word)
                              && is_word(mask_r[g]);
        assign entry_wdata[g] = wdata_r[g];
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Store payload into the tail slot
    always_ff @(posedge clk) begin
        if (push) begin
            addr_r[tail_r]  <= push_addr;
            wdata_r[tail_r] <= push_wdata;
            mask_r[tail_r]  <= push_mask;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and data memory with
// full-word store-to-load forwarding; other loads wait for the buffer to drain.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy
);

    logic                   push_s, pop_s, full_s, empty_s;
    logic [31:0]            head_addr_s, head_wdata_s;
    logic [3:0]             head_mask_s;
    logic [PTR_W-1:0]       head_ptr_s, fwd_idx_s;
    logic [DEPTH-1:0]       match_s;
    logic [DEPTH-1:0][31:0] entry_wdata_s;

    sb_state_e   state_r, state_nxt_s;
    logic        mem_read_r, mem_write_r, seen_busy_r;
    logic [31:0] mem_addr_r, mem_wdata_r, cpu_rdata_r;
    logic [3:0]  mem_sign_mask_r;

    logic        load_s, store_s, op_s, done_s, hit_s, fwd_hit_s;
    logic        issue_wr_s, issue_rd_s, capture_s, load_stall_s;
    logic [31:0] fwd_data_s, rdata_s;

    sb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push_s),
        .pop         (pop_s),
        .push_addr   (cpu_addr),
        .push_wdata  (cpu_wdata),
        .push_mask   (cpu_sign_mask),
        .cmp_word    (cpu_addr[31:2]),
        .head_addr   (head_addr_s),
        .head_wdata  (head_wdata_s),
        .head_mask   (head_mask_s),
        .head_ptr    (head_ptr_s),
        .full        (full_s),
        .empty       (empty_s),
        .match       (match_s),
        .entry_wdata (entry_wdata_s)
    );

    sb_checker u_checker (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .mem_read  (mem_read_r),
        .mem_write (mem_write_r)
    );

    // A write is dropped when it collides with a read on the same cycle
    assign load_s  = cpu_read;
    assign store_s = cpu_write & ~cpu_read;
    assign push_s  = store_s & ~full_s;
    assign op_s    = mem_read_r | mem_write_r;
    assign done_s  = op_s & seen_busy_r & ~mem_busy;
    assign hit_s   = fwd_hit_s & is_word(cpu_sign_mask);

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        fwd_idx_s  = head_ptr_s;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx_s  = head_ptr_s + PTR_W'(k);
            fwd_hit_s  = fwd_hit_s | match_s[fwd_idx_s];
            fwd_data_s = match_s[fwd_idx_s] ? entry_wdata_s[fwd_idx_s] : fwd_data_s;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt_s  = state_r;
        issue_wr_s   = 1'b0;
        issue_rd_s   = 1'b0;
        pop_s        = 1'b0;
        capture_s    = 1'b0;
        load_stall_s = 1'b0;
        rdata_s      = cpu_rdata_r;
        case (state_r)
            SB_IDLE: begin
                if (load_s && hit_s) begin
                    rdata_s = fwd_data_s;
                end else begin
                    rdata_s = cpu_rdata_r;
                end
                if (load_s && !hit_s && empty_s) begin
                    load_stall_s = 1'b1;
                    issue_rd_s   = 1'b1;
                    state_nxt_s  = SB_LOAD;
                end else if (load_s && !hit_s) begin
                    load_stall_s = 1'b1;
                    issue_wr_s   = 1'b1;
                    state_nxt_s  = SB_LOAD_WAIT_DRAIN;
                end else if (!empty_s) begin
                    issue_wr_s  = 1'b1;
                    state_nxt_s = SB_DRAIN;
                end else begin
                    state_nxt_s = SB_IDLE;
                end
            end
            SB_DRAIN: begin
                pop_s = done_s;
                if (load_s && hit_s) begin
                    rdata_s     = fwd_data_s;
                    state_nxt_s = done_s ? SB_IDLE : SB_DRAIN;
                end else if (load_s) begin
                    load_stall_s = 1'b1;
                    state_nxt_s  = SB_LOAD_WAIT_DRAIN;
                end else if (done_s) begin
                    state_nxt_s = SB_IDLE;
                end else begin
                    state_nxt_s = SB_DRAIN;
                end
            end
            SB_LOAD_WAIT_DRAIN: begin
                load_stall_s = 1'b1;
                if (op_s) begin
                    pop_s = done_s;
                end else if (!empty_s) begin
                    issue_wr_s = 1'b1;
                end else begin
                    issue_rd_s  = 1'b1;
                    state_nxt_s = SB_LOAD;
                end
            end
            SB_LOAD: begin
                load_stall_s = 1'b1;
                if (done_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = SB_LOAD_DONE;
                end else begin
                    state_nxt_s = SB_LOAD;
                end
            end
            SB_LOAD_DONE: begin
                state_nxt_s = SB_IDLE;
            end
            default: begin
                state_nxt_s = SB_IDLE;
            end
        endcase
    end

    // State, memory request and load-result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= SB_IDLE;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            mem_addr_r      <= 32'h0000_0000;
            mem_wdata_r     <= 32'h0000_0000;
            mem_sign_mask_r <= 4'h0;
            seen_busy_r     <= 1'b0;
            cpu_rdata_r     <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (done_s) begin
                mem_read_r  <= 1'b0;
                mem_write_r <= 1'b0;
                seen_busy_r <= 1'b0;
            end else if (issue_wr_s) begin
                mem_write_r     <= 1'b1;
                mem_addr_r      <= head_addr_s;
                mem_wdata_r     <= head_wdata_s;
                mem_sign_mask_r <= head_mask_s;
            end else if (issue_rd_s) begin
                mem_read_r      <= 1'b1;
                mem_addr_r      <= cpu_addr;
                mem_wdata_r     <= 32'h0000_0000;
                mem_sign_mask_r <= cpu_sign_mask;
            end else if (op_s && mem_busy) begin
                seen_busy_r <= 1'b1;
            end
            if (capture_s) begin
                cpu_rdata_r <= mem_rdata;
            end
        end
    end

    assign cpu_stall     = load_stall_s | (store_s & full_s);
    assign cpu_rdata     = rdata_s;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_sign_mask = mem_sign_mask_r;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a busy-handshake memory model, expected
// memory operations and load results queued at issue, checked by monitors.
`timescale 1ns/1ps
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_sign_mask;
    logic        cpu_stall;
    logic        mem_read, mem_write, mem_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sign_mask;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_sign_mask(cpu_sign_mask),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } mem_op_t;

    int          checks = 0;
    int          errors = 0;
    mem_op_t     exp_ops[$];
    logic [31:0] exp_loads[$];
    mem_op_t     mon_op;
    logic [31:0] mem_arr [0:255];
    int          mstate = 0;
    int          mcnt = 0;
    logic        m_write;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_mask;
    localparam int LAT = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Little-endian read with size and sign extension as the data memory does it
    function automatic logic [31:0] read_model(input logic [31:0] a, input logic [3:0] m);
        logic [31:0] w, sb, sh;
        w  = mem_arr[a[9:2]];
        sb = w >> {a[1:0], 3'b000};
        sh = w >> {a[1], 4'b0000};
        if (m[2])      return w;
        else if (m[1]) return {{16{m[3] & sh[15]}}, sh[15:0]};
        else if (m[0]) return {{24{m[3] & sb[7]}}, sb[7:0]};
        else           return 32'h0;
    endfunction

    // Memory model: accept, hold busy LAT+1 cycles, then wait for the request to drop
    always @(posedge clk) begin
        if (reset) begin
            mstate   <= 0;
            mem_busy <= 1'b0;
        end else begin
            case (mstate)
                0: if (mem_read || mem_write) begin
                    m_write <= mem_write; m_addr <= mem_addr;
                    m_data <= mem_wdata; m_mask <= mem_sign_mask;
                    mem_busy <= 1'b1; mcnt <= LAT; mstate <= 1;
                end
                1: if (mcnt == 0) begin
                    mem_busy <= 1'b0;
                    if (m_write) mem_arr[m_addr[9:2]] <= m_data;
                    else mem_rdata <= read_model(m_addr, m_mask);
                    mstate <= 2;
                end else begin
                    mcnt <= mcnt - 1;
                end
                2: if (!(mem_read || mem_write)) mstate <= 0;
                default: mstate <= 0;
            endcase
        end
    end

    // Monitor: every new memory request is compared against the expected-op queue
    always @(negedge clk) begin
        if (!reset && mstate == 0 && (mem_read || mem_write)) begin
            if (exp_ops.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_op_unexpected actual=wr%0d@0x%08h required=none", mem_write, mem_addr);
            end else begin
                mon_op = exp_ops.pop_front();
                check("mem_op_kind", {31'h0, mem_write}, {31'h0, mon_op.is_write});
                check("mem_op_addr", mem_addr, mon_op.addr);
                check("mem_op_mask", {28'h0, mem_sign_mask}, {28'h0, mon_op.mask});
                if (mon_op.is_write) check("mem_op_wdata", mem_wdata, mon_op.data);
            end
        end
    end

    // Monitor: a load completes whenever cpu_read is high and the core is not stalled
    always @(negedge clk) begin
        if (!reset && cpu_read && !cpu_stall) begin
            if (exp_loads.size() == 0) begin
                checks++; errors++;
                $display("FAIL load_unexpected actual=0x%08h required=none", cpu_rdata);
            end else begin
                check("load_data", cpu_rdata, exp_loads.pop_front());
            end
        end
    end

    task automatic wait_release(input string name, output int stalls);
        bit ok = 1'b0;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin ok = 1'b1; break; end
            stalls++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_timeout actual=stalled required=released", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit exp_drain, output int stalls);
        cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_sign_mask = 4'b0100;
        if (exp_drain) exp_ops.push_back('{is_write: 1'b1, addr: a, data: d, mask: 4'b0100});
        wait_release("store", stalls);
        cpu_write = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] m, input logic [31:0] exp_d,
                           input bit to_mem, output int stalls);
        cpu_read = 1'b1; cpu_addr = a; cpu_sign_mask = m;
        exp_loads.push_back(exp_d);
        if (to_mem) exp_ops.push_back('{is_write: 1'b0, addr: a, data: 32'h0, mask: m});
        wait_release("load", stalls);
        cpu_read = 1'b0;
    endtask

    task automatic wait_drain();
        int quiet = 0;
        for (int i = 0; i < 1000 && quiet < 4; i++) begin
            @(negedge clk);
            if (mstate == 0 && !mem_read && !mem_write) quiet++;
            else quiet = 0;
        end
        if (quiet < 4) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int st;
        int st5 [5];
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_sign_mask = 4'h0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_stall", {31'h0, cpu_stall}, 32'h0);
        check("rst_mem_read",  {31'h0, mem_read},  32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_mask",  {28'h0, mem_sign_mask}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: three stores retire without stalls and drain in order
        do_store(32'h10, 32'hA, 1'b1, st); check("t1_stall0", st, 0);
        do_store(32'h14, 32'hB, 1'b1, st); check("t1_stall1", st, 0);
        do_store(32'h18, 32'hC, 1'b1, st); check("t1_stall2", st, 0);
        wait_drain();
        check("t1_mem10", mem_arr[4], 32'hA);
        check("t1_mem14", mem_arr[5], 32'hB);
        check("t1_mem18", mem_arr[6], 32'hC);

        // 2: fifth back-to-back store stalls on a full buffer
        for (int i = 0; i < 5; i++) begin
            do_store(32'h100 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b1, st);
            st5[i] = st;
        end
        for (int i = 0; i < 4; i++) check("t2_no_stall", st5[i], 0);
        check("t2_store5_stalled", (st5[4] > 0) ? 32'h1 : 32'h0, 32'h1);
        wait_drain();
        for (int i = 0; i < 5; i++) check("t2_mem", mem_arr[64 + i], 32'h5000_0000 + 32'(i));

        // 3: word load forwarded from the buffer with no stall
        do_store(32'h40, 32'hDEADBEEF, 1'b1, st);
        do_load(32'h40, 4'b0100, 32'hDEADBEEF, 1'b0, st);
        check("t3_fwd_stall", st, 0);
        wait_drain();

        // 4: signed byte load misses forwarding, drains, then reads memory
        do_store(32'h40, 32'h11223344, 1'b1, st);
        do_load(32'h43, 4'b1001, 32'h0000_0011, 1'b1, st);
        check("t4_load_stalled", (st > 0) ? 32'h1 : 32'h0, 32'h1);
        wait_drain();

        // 5: youngest of two matching entries is forwarded
        do_store(32'h40, 32'h1, 1'b1, st);
        do_store(32'h40, 32'h2, 1'b1, st);
        do_load(32'h40, 4'b0100, 32'h2, 1'b0, st);
        check("t5_fwd_stall", st, 0);
        wait_drain();
        check("t5_mem40", mem_arr[16], 32'h2);

        // 6: reset during a drain discards queued stores
        do_store(32'h80, 32'h55, 1'b1, st);
        do_store(32'h84, 32'h66, 1'b0, st);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (mem_write) begin seen = 1'b1; break; end
            end
            check("t6_drain_issued", {31'h0, seen}, 32'h1);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_mem_write_low", {31'h0, mem_write}, 32'h0);
        check("t6_mem_addr_low", mem_addr, 32'h0);
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_addr = 32'h84; cpu_sign_mask = 4'b0100;
        exp_loads.push_back(32'h0);
        exp_ops.push_back('{is_write: 1'b0, addr: 32'h84, data: 32'h0, mask: 4'b0100});
        @(negedge clk);
        check("t6_load_stall", {31'h0, cpu_stall}, 32'h1);
        @(negedge clk);
        check("t6_read_immediate", {31'h0, mem_read}, 32'h1);
        @(posedge clk); #1;
        wait_release("t6_load", st);
        cpu_read = 1'b0;
        wait_drain();

        check("ops_queue_empty", exp_ops.size(), 0);
        check("loads_queue_empty", exp_loads.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
